// File: rtl/viterbi_pkg.sv
// Code definition shared by the rate-1/2, K=3 encoder and its Viterbi decoder.
package viterbi_pkg;

   localparam int K = 3;
   localparam logic [2:0] G0 = 3'b111;
   localparam logic [2:0] G1 = 3'b101;
   localparam int NSTATES = 4;

   typedef logic [1:0] state_t;

   // Symbol emitted when input bit b enters an encoder in state {s1, s0}.
   function automatic logic [1:0] expected_sym(state_t state, logic b);
      logic [2:0] taps;
      taps = {b, state};
      return {^(taps & G0), ^(taps & G1)};
   endfunction

endpackage

// File: rtl/encoder2.sv
// Rate-1/2, K=3 convolutional encoder (g0 = 111, g1 = 101) used as the code reference.
module encoder2
   import viterbi_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       enable_i,
   input  logic       d_in,
   output logic       valid_o,
   output logic [1:0] d_out
);

   state_t     s_q, s_d;
   logic [1:0] d_out_q, d_out_d;
   logic       valid_q, valid_d;

   always_comb begin
      s_d     = s_q;
      d_out_d = 2'b00;
      valid_d = enable_i;
      if (enable_i) begin
         d_out_d = expected_sym(s_q, d_in);
         s_d     = {d_in, s_q[1]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_q     <= 2'b00;
         d_out_q <= 2'b00;
         valid_q <= 1'b0;
      end else begin
         s_q     <= s_d;
         d_out_q <= d_out_d;
         valid_q <= valid_d;
      end
   end

   assign d_out   = d_out_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/viterbi_acs.sv
// One add-compare-select unit: saturating adds, ties go to the s0 = 0 predecessor.
module viterbi_acs #(
   parameter int PM_W = 7
) (
   input  logic [PM_W-1:0] pm0_i,
   input  logic [PM_W-1:0] pm1_i,
   input  logic [1:0]      bm0_i,
   input  logic [1:0]      bm1_i,
   output logic [PM_W-1:0] pm_o,
   output logic            dec_o
);

   logic [PM_W:0]   sum0, sum1;
   logic [PM_W-1:0] sat0, sat1;

   always_comb begin
      sum0 = {1'b0, pm0_i} + {{(PM_W-1){1'b0}}, bm0_i};
      sum1 = {1'b0, pm1_i} + {{(PM_W-1){1'b0}}, bm1_i};
      // The carry out marks an overflow, so clamp to the all-ones ceiling.
      sat0 = sum0[PM_W] ? {PM_W{1'b1}} : sum0[PM_W-1:0];
      sat1 = sum1[PM_W] ? {PM_W{1'b1}} : sum1[PM_W-1:0];
      dec_o = (sat1 < sat0);
      pm_o  = dec_o ? sat1 : sat0;
   end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision register-exchange Viterbi decoder for the encoder2 code.
module viterbi_decoder
   import viterbi_pkg::*;
#(
   parameter int TB_DEPTH = 16,
   parameter int PM_W     = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [1:0] d_in,
   output logic       d_out
);

   localparam logic [PM_W-1:0] PM_MAX = {PM_W{1'b1}};

   logic [PM_W-1:0]     pm_q [NSTATES];
   logic [PM_W-1:0]     pm_d [NSTATES];
   logic [PM_W-1:0]     acs_pm [NSTATES];
   logic                acs_dec [NSTATES];
   logic [TB_DEPTH-1:0] surv_q [NSTATES];
   logic [TB_DEPTH-1:0] surv_d [NSTATES];
   logic [TB_DEPTH-1:0] surv_new [NSTATES];
   logic                d_out_q, d_out_d;
   logic [PM_W-1:0]     min_pm;
   state_t              best;

   // New state {b, x} is reached from {x, 0} and {x, 1} by input bit b.
   for (genvar gi = 0; gi < NSTATES; gi++) begin : g_state
      localparam int   P0 = (gi % 2) * 2;
      localparam int   P1 = P0 + 1;
      localparam logic NB = 1'(gi / 2);

      logic [1:0]          e0, e1, bm0, bm1;
      logic [TB_DEPTH-1:0] prev_surv;

      assign e0  = expected_sym(state_t'(P0), NB) ^ d_in;
      assign e1  = expected_sym(state_t'(P1), NB) ^ d_in;
      assign bm0 = {e0[1] & e0[0], e0[1] ^ e0[0]};
      assign bm1 = {e1[1] & e1[0], e1[1] ^ e1[0]};

      viterbi_acs #(.PM_W(PM_W)) u_acs (
         .pm0_i (pm_q[P0]),
         .pm1_i (pm_q[P1]),
         .bm0_i (bm0),
         .bm1_i (bm1),
         .pm_o  (acs_pm[gi]),
         .dec_o (acs_dec[gi])
      );

      assign prev_surv    = acs_dec[gi] ? surv_q[P1] : surv_q[P0];
      assign surv_new[gi] = {prev_surv[TB_DEPTH-2:0], NB};
   end

   always_comb begin
      min_pm  = acs_pm[0];
      best    = 2'd0;
      for (int i = 1; i < NSTATES; i++) begin
         if (acs_pm[i] < min_pm) begin
            min_pm = acs_pm[i];
            best   = state_t'(i);
         end
      end
      d_out_d = d_out_q;
      for (int i = 0; i < NSTATES; i++) begin
         pm_d[i]   = pm_q[i];
         surv_d[i] = surv_q[i];
      end
      if (enable) begin
         for (int i = 0; i < NSTATES; i++) begin
            pm_d[i]   = acs_pm[i] - min_pm;
            surv_d[i] = surv_new[i];
         end
         d_out_d = surv_new[best][TB_DEPTH-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NSTATES; i++) begin
            pm_q[i]   <= (i == 0) ? '0 : PM_MAX;
            surv_q[i] <= '0;
         end
         d_out_q <= 1'b0;
      end else begin
         for (int i = 0; i < NSTATES; i++) begin
            pm_q[i]   <= pm_d[i];
            surv_q[i] <= surv_d[i];
         end
         d_out_q <= d_out_d;
      end
   end

   assign d_out = d_out_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// Self-checking bench for viterbi_decoder with encoder2 run alongside on the same input bits.
module tb_viterbi_decoder;

   localparam int TB_DEPTH = 16;
   localparam int PM_W     = 7;
   localparam logic [PM_W-1:0] PM_MAX = {PM_W{1'b1}};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       dec_en = 1'b0;
   logic [1:0] dec_sym = 2'b00;
   logic       dec_out;
   logic       enc_en = 1'b0;
   logic       enc_d = 1'b0;
   logic       enc_valid;
   logic [1:0] enc_out;

   int checks = 0;
   int errors = 0;

   // Reference state: the last two input bits and the history of sent bits.
   bit h1, h2;
   bit sent[$];
   int n_sym;
   logic last_out;

   typedef struct {
      bit         d;
      logic [1:0] exp_sym;
   } enc_vec_t;
   enc_vec_t golden[6];

   always #5 clk = ~clk;

   viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .enable (dec_en),
      .d_in   (dec_sym),
      .d_out  (dec_out)
   );

   encoder2 u_enc (
      .clk      (clk),
      .rst      (rst),
      .enable_i (enc_en),
      .d_in     (enc_d),
      .valid_o  (enc_valid),
      .d_out    (enc_out)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_model();
      h1 = 0;
      h2 = 0;
      sent.delete();
      n_sym = 0;
      last_out = 1'b0;
   endtask

   task automatic chk_reset_state();
      chk("rst_dec_out", {31'd0, dec_out}, 32'd0);
      chk("rst_enc_out", {30'd0, enc_out}, 32'd0);
      chk("rst_enc_valid", {31'd0, enc_valid}, 32'd0);
      for (int i = 0; i < 4; i++)
         chk("rst_pm", {{(32-PM_W){1'b0}}, dut.pm_q[i]}, (i == 0) ? 32'd0 : {{(32-PM_W){1'b0}}, PM_MAX});
   endtask

   // Called at posedge+1: asserts reset asynchronously, checks, releases away from the edge.
   task automatic do_reset();
      enc_en = 1'b0;
      dec_en = 1'b0;
      rst = 1'b0;
      #2;
      chk_reset_state();
      @(posedge clk);
      #1;
      rst = 1'b1;
      clear_model();
   endtask

   // One enabled symbol: code bits from the generator rules, decoder expects input delayed by TB_DEPTH-1.
   task automatic send(input bit b, input logic [1:0] flip);
      logic [1:0] sym;
      int idx;
      sym = {b ^ h1 ^ h2, b ^ h2};
      enc_en  = 1'b1;
      enc_d   = b;
      dec_en  = 1'b1;
      dec_sym = sym ^ flip;
      @(posedge clk);
      #1;
      enc_en = 1'b0;
      dec_en = 1'b0;
      chk("enc_sym", {30'd0, enc_out}, {30'd0, sym});
      chk("enc_valid", {31'd0, enc_valid}, 32'd1);
      sent.push_back(b);
      idx = n_sym - (TB_DEPTH - 1);
      chk("dec_bit", {31'd0, dec_out}, (idx >= 0) ? {31'd0, sent[idx]} : 32'd0);
      n_sym++;
      h2 = h1;
      h1 = b;
      last_out = dec_out;
   endtask

   task automatic idle();
      enc_en = 1'b0;
      dec_en = 1'b0;
      dec_sym = 2'(h1 ? 3 : 1);
      @(posedge clk);
      #1;
      chk("dec_hold", {31'd0, dec_out}, {31'd0, last_out});
      chk("enc_idle_out", {30'd0, enc_out}, 32'd0);
      chk("enc_idle_valid", {31'd0, enc_valid}, 32'd0);
   endtask

   initial begin
      golden[0] = '{1'b1, 2'b11};
      golden[1] = '{1'b0, 2'b10};
      golden[2] = '{1'b1, 2'b00};
      golden[3] = '{1'b1, 2'b01};
      golden[4] = '{1'b0, 2'b01};
      golden[5] = '{1'b0, 2'b11};

      @(posedge clk);
      #1;
      do_reset();

      // Encoder golden vector from reset.
      for (int i = 0; i < 6; i++) begin
         send(golden[i].d, 2'b00);
         chk("enc_golden", {30'd0, enc_out}, {30'd0, golden[i].exp_sym});
      end

      // All-zero stream.
      do_reset();
      for (int i = 0; i < 64; i++) begin
         send(1'b0, 2'b00);
         chk("zeros_out", {31'd0, dec_out}, 32'd0);
      end

      // Clean random stream.
      do_reset();
      for (int i = 0; i < 256; i++)
         send(1'($urandom_range(0, 1)), 2'b00);

      // One flipped code bit every 16 symbols; metrics must stay below the ceiling.
      do_reset();
      for (int i = 0; i < 256; i++) begin
         send(1'($urandom_range(0, 1)), (i % 16 == 8) ? 2'(1 << $urandom_range(0, 1)) : 2'b00);
         if (i >= 2) begin
            for (int s = 0; s < 4; s++)
               chk("pm_nosat", {31'd0, dut.pm_q[s] < PM_MAX}, 32'd1);
         end
      end

      // Enable gaps mid-stream.
      do_reset();
      for (int i = 0; i < 40; i++)
         send(1'($urandom_range(0, 1)), 2'b00);
      for (int i = 0; i < 3; i++)
         idle();
      for (int i = 0; i < 40; i++)
         send(1'($urandom_range(0, 1)), 2'b00);

      // Reset at symbol 100, then a fresh stream with start-up latency.
      do_reset();
      for (int i = 0; i < 100; i++)
         send(1'($urandom_range(0, 1)), 2'b00);
      do_reset();
      for (int i = 0; i < 100; i++)
         send(1'($urandom_range(0, 1)), 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
